// File: rtl/div_scheduler.sv
// div_scheduler: shares one iterative 64-bit divider between two issue ports.
// Round-robin arbitration, registered divider operands, one-cycle start
// pulse, tagged result held until writeback accepts it, flush of the
// in-flight op.
// Optional build macro: DIV_ZERO_BYPASS_EN (divide-by-zero answered locally).
module div_scheduler #(
    parameter int PRF_WIDTH = 6
) (
    input  logic                   i_clk,
    input  logic                   i_rst,          // async, active-low
    input  logic [1:0]             i_req_valid,
    output logic [1:0]             o_req_ready,
    input  logic [127:0]           i_req_dividend,
    input  logic [127:0]           i_req_divisor,
    input  logic [19:0]            i_req_op,
    input  logic [2*PRF_WIDTH-1:0] i_req_tag,
    input  logic                   i_flush,
    output logic [63:0]            o_div_dividend,
    output logic [63:0]            o_div_divisor,
    output logic [9:0]             o_div_op,
    output logic                   o_div_start,
    input  logic [63:0]            i_div_result,
    input  logic                   i_div_finish,
    input  logic                   i_div_busy,
    output logic                   o_res_valid,
    input  logic                   i_res_ready,
    output logic [63:0]            o_res_data,
    output logic [PRF_WIDTH-1:0]   o_res_tag,
    output logic                   o_res_port
);

    typedef enum logic [1:0] {IDLE, ISSUE, WAIT, DONE} state_t;

    state_t               r_state, w_next;
    logic                 r_rr_ptr;
    logic                 r_kill;
    logic [63:0]          r_div_dividend, r_div_divisor, r_res_data;
    logic [9:0]           r_div_op;
    logic [PRF_WIDTH-1:0] r_res_tag;
    logic                 r_res_port;

    logic [1:0]           w_grant;
    logic                 w_accept, w_win;
    logic                 w_set_kill, w_clr_kill;
    logic [63:0]          w_sel_dividend, w_sel_divisor;
    logic [9:0]           w_sel_op;
    logic [PRF_WIDTH-1:0] w_sel_tag;
    logic                 w_bypass;
    logic [63:0]          w_bypass_data;

    // Round-robin grant: a lone requester wins, a tie goes to r_rr_ptr
    always_comb begin
        w_grant = 2'b00;
        case (i_req_valid)
            2'b01:   w_grant = 2'b01;
            2'b10:   w_grant = 2'b10;
            2'b11:   w_grant = r_rr_ptr ? 2'b10 : 2'b01;
            default: w_grant = 2'b00;
        endcase
    end

    // Accept only in IDLE with the divider free and no flush; gating with
    // the reset input keeps req_ready low while reset is held.
    assign o_req_ready = w_grant & {2{(r_state == IDLE) & ~i_div_busy & ~i_flush & i_rst}};
    assign w_accept    = |o_req_ready;
    assign w_win       = o_req_ready[1];

    assign w_sel_dividend = w_win ? i_req_dividend[127:64] : i_req_dividend[63:0];
    assign w_sel_divisor  = w_win ? i_req_divisor[127:64]  : i_req_divisor[63:0];
    assign w_sel_op       = w_win ? i_req_op[19:10]        : i_req_op[9:0];
    assign w_sel_tag      = w_win ? i_req_tag[2*PRF_WIDTH-1:PRF_WIDTH] : i_req_tag[PRF_WIDTH-1:0];

`ifdef DIV_ZERO_BYPASS_EN
    logic w_is_w, w_div_zero;
    // Divide-by-zero answered locally with the RISC-V defined results
    always_comb begin
        w_is_w     = (w_sel_op[9:3] == 7'b0111011);
        w_div_zero = w_is_w ? (w_sel_divisor[31:0] == 32'd0) : (w_sel_divisor == 64'd0);
        w_bypass   = w_div_zero;
        if (!w_sel_op[1])
            w_bypass_data = 64'hFFFF_FFFF_FFFF_FFFF;          // div/divu/divw/divuw
        else if (w_is_w)
            w_bypass_data = {{32{w_sel_dividend[31]}}, w_sel_dividend[31:0]};
        else
            w_bypass_data = w_sel_dividend;                     // rem/remu
    end
`else
    assign w_bypass      = 1'b0;
    assign w_bypass_data = 64'd0;
`endif

    // Next-state logic; kill marks an op whose result must be dropped
    always_comb begin
        w_next     = r_state;
        w_set_kill = 1'b0;
        w_clr_kill = 1'b0;
        case (r_state)
            IDLE:  if (w_accept) w_next = w_bypass ? DONE : ISSUE;
            ISSUE: begin
                w_next     = WAIT;
                w_set_kill = i_flush;
            end
            WAIT: begin
                if (i_div_finish) begin
                    if (r_kill || i_flush) begin
                        w_next     = IDLE;
                        w_clr_kill = 1'b1;
                    end else begin
                        w_next = DONE;
                    end
                end else begin
                    w_set_kill = i_flush;
                end
            end
            DONE:  if (i_flush || i_res_ready) w_next = IDLE;
            default: w_next = IDLE;
        endcase
    end

    // State, arbitration pointer and kill flag
    always_ff @(posedge i_clk or negedge i_rst) begin
        if (!i_rst) begin
            r_state  <= IDLE;
            r_rr_ptr <= 1'b0;
            r_kill   <= 1'b0;
        end else begin
            r_state <= w_next;
            if (w_accept)        r_rr_ptr <= ~w_win;
            if (w_clr_kill)      r_kill   <= 1'b0;
            else if (w_set_kill) r_kill   <= 1'b1;
        end
    end

    // Operand/result registers; divider operands hold until the next accept
    always_ff @(posedge i_clk or negedge i_rst) begin
        if (!i_rst) begin
            r_div_dividend <= '0;
            r_div_divisor  <= '0;
            r_div_op       <= '0;
            r_res_data     <= '0;
            r_res_tag      <= '0;
            r_res_port     <= 1'b0;
        end else begin
            if (w_accept) begin
                r_div_dividend <= w_sel_dividend;
                r_div_divisor  <= w_sel_divisor;
                r_div_op       <= w_sel_op;
                r_res_tag      <= w_sel_tag;
                r_res_port     <= w_win;
                if (w_bypass) r_res_data <= w_bypass_data;
            end
            if (r_state == WAIT && i_div_finish) r_res_data <= i_div_result;
        end
    end

    assign o_div_start    = (r_state == ISSUE);
    assign o_res_valid    = (r_state == DONE);
    assign o_div_dividend = r_div_dividend;
    assign o_div_divisor  = r_div_divisor;
    assign o_div_op       = r_div_op;
    assign o_res_data     = r_res_data;
    assign o_res_tag      = r_res_tag;
    assign o_res_port     = r_res_port;

endmodule
